// File: rtl/cajero_controlador_pkg.sv
// Shared definitions for the cashier controller: FSM states, transaction
// type codes and default widths.
package cajero_defs;

    localparam int unsigned PIN_DIGITOS_DEF   = 4;
    localparam int unsigned MAX_INTENTOS_DEF  = 3;
    localparam int unsigned ANCHO_BALANCE_DEF = 64;
    localparam int unsigned ANCHO_MONTO_DEF   = 32;

    localparam logic TRANS_DEPOSITO = 1'b0;
    localparam logic TRANS_RETIRO   = 1'b1;

    typedef enum logic [2:0] {
        ESPERA_TARJETA,
        RECIBIR_PIN,
        VERIFICAR_PIN,
        ESPERA_MONTO,
        PROCESAR,
        BLOQUEO
    } estado_t;

endpackage

// File: rtl/cajero_controlador_pin_captura.sv
// PIN capture: nibble shift register, digit counter and comparison against
// the stored PIN.
module cajero_pin_captura
    import cajero_defs::*;
#(
    parameter int unsigned PIN_DIGITOS = PIN_DIGITOS_DEF
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     captura_i,
    input  logic [3:0]               digito_i,
    input  logic [4*PIN_DIGITOS-1:0] pin_i,
    output logic                     pin_completo_o,
    output logic                     pin_coincide_o
);

    localparam int unsigned PW = 4 * PIN_DIGITOS;
    localparam int unsigned CW = (PIN_DIGITOS > 1) ? $clog2(PIN_DIGITOS) : 1;

    logic [PW-1:0] shift_q;
    logic [CW-1:0] cnt_q;

    // The last digit of an attempt wraps the counter, so each retry starts fresh.
    always_comb begin
        pin_completo_o = captura_i && (cnt_q == CW'(PIN_DIGITOS - 1));
        pin_coincide_o = (shift_q == pin_i);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (captura_i) begin
            shift_q <= (shift_q << 4) | PW'(digito_i);
            cnt_q   <= pin_completo_o ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/cajero_controlador.sv
// Cashier sequencing FSM: card acceptance, PIN verification with lockout,
// and a single deposit or withdrawal against the latched balance.
module cajero_controlador
    import cajero_defs::*;
#(
    parameter int unsigned PIN_DIGITOS   = PIN_DIGITOS_DEF,
    parameter int unsigned MAX_INTENTOS  = MAX_INTENTOS_DEF,
    parameter int unsigned ANCHO_BALANCE = ANCHO_BALANCE_DEF,
    parameter int unsigned ANCHO_MONTO   = ANCHO_MONTO_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     tarjeta_recibida,
    input  logic                     tipo_trans,
    input  logic                     digito_stb,
    input  logic [3:0]               digito,
    input  logic [4*PIN_DIGITOS-1:0] pin,
    input  logic [ANCHO_BALANCE-1:0] balance_inicial,
    input  logic [ANCHO_MONTO-1:0]   monto,
    input  logic                     monto_stb,
    output logic [ANCHO_BALANCE-1:0] balance,
    output logic                     balance_actualizado,
    output logic                     entregar_dinero,
    output logic                     pin_incorrecto,
    output logic                     advertencia,
    output logic                     bloqueo,
    output logic                     fondos_insuficientes
);

    localparam int unsigned AW = $clog2(MAX_INTENTOS + 1);

    estado_t                  estado_q;
    logic [ANCHO_BALANCE-1:0] balance_q;
    logic [ANCHO_MONTO-1:0]   monto_q;
    logic                     tipo_q;
    logic [AW-1:0]            intentos_q;
    logic                     act_q, ent_q, inc_q, adv_q, blo_q, fi_q;

    logic                     captura;
    logic                     pin_completo, pin_coincide;
    logic [AW-1:0]            intentos_d;
    logic [ANCHO_BALANCE-1:0] monto_ext_d, suma_d, resta_d;
    logic                     fondos_ok_d;

    always_comb begin
        captura     = (estado_q == RECIBIR_PIN) && digito_stb;
        intentos_d  = intentos_q + AW'(1);
        monto_ext_d = ANCHO_BALANCE'(monto_q);
        suma_d      = balance_q + monto_ext_d;
        resta_d     = balance_q - monto_ext_d;
        fondos_ok_d = (monto_ext_d <= balance_q);
    end

    cajero_pin_captura #(
        .PIN_DIGITOS (PIN_DIGITOS)
    ) u_pin_captura (
        .clock_i        (clock),
        .reset_i        (reset),
        .captura_i      (captura),
        .digito_i       (digito),
        .pin_i          (pin),
        .pin_completo_o (pin_completo),
        .pin_coincide_o (pin_coincide)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= ESPERA_TARJETA;
            balance_q  <= '0;
            monto_q    <= '0;
            tipo_q     <= 1'b0;
            intentos_q <= '0;
            act_q      <= 1'b0;
            ent_q      <= 1'b0;
            inc_q      <= 1'b0;
            adv_q      <= 1'b0;
            blo_q      <= 1'b0;
            fi_q       <= 1'b0;
        end else begin
            act_q <= 1'b0;
            ent_q <= 1'b0;
            inc_q <= 1'b0;
            fi_q  <= 1'b0;
            case (estado_q)
                ESPERA_TARJETA: begin
                    if (tarjeta_recibida) begin
                        balance_q <= balance_inicial;
                        tipo_q    <= tipo_trans;
                        estado_q  <= RECIBIR_PIN;
                    end
                end
                RECIBIR_PIN: begin
                    if (pin_completo) estado_q <= VERIFICAR_PIN;
                end
                VERIFICAR_PIN: begin
                    if (pin_coincide) begin
                        intentos_q <= '0;
                        adv_q      <= 1'b0;
                        estado_q   <= ESPERA_MONTO;
                    end else begin
                        intentos_q <= intentos_d;
                        inc_q      <= 1'b1;
                        if (intentos_d == AW'(MAX_INTENTOS)) begin
                            blo_q    <= 1'b1;
                            adv_q    <= 1'b1;
                            estado_q <= BLOQUEO;
                        end else begin
                            if (intentos_d == AW'(MAX_INTENTOS - 1)) adv_q <= 1'b1;
                            estado_q <= RECIBIR_PIN;
                        end
                    end
                end
                ESPERA_MONTO: begin
                    if (monto_stb) begin
                        monto_q  <= monto;
                        estado_q <= PROCESAR;
                    end
                end
                PROCESAR: begin
                    if (tipo_q == TRANS_DEPOSITO) begin
                        balance_q <= suma_d;
                        act_q     <= 1'b1;
                    end else if (fondos_ok_d) begin
                        balance_q <= resta_d;
                        act_q     <= 1'b1;
                        ent_q     <= 1'b1;
                    end else begin
                        fi_q <= 1'b1;
                    end
                    estado_q <= ESPERA_TARJETA;
                end
                BLOQUEO: begin
                    blo_q <= 1'b1;
                    adv_q <= 1'b1;
                end
                default: estado_q <= ESPERA_TARJETA;
            endcase
        end
    end

    assign balance              = balance_q;
    assign balance_actualizado  = act_q;
    assign entregar_dinero      = ent_q;
    assign pin_incorrecto       = inc_q;
    assign advertencia          = adv_q;
    assign bloqueo              = blo_q;
    assign fondos_insuficientes = fi_q;

endmodule

// File: tb/tb_cajero_controlador.sv
// Bench for cajero_controlador: directed table, hand sequences and random
// sessions checked against a transaction-level account model.
module tb_cajero_controlador;

    localparam int          MAXI   = 3;
    localparam logic [15:0] PIN_OK = 16'h1234;

    logic        clock = 1'b0;
    logic        reset, tarjeta_recibida, tipo_trans, digito_stb, monto_stb;
    logic [3:0]  digito;
    logic [15:0] pin;
    logic [63:0] balance_inicial, balance;
    logic [31:0] monto;
    logic        balance_actualizado, entregar_dinero, pin_incorrecto;
    logic        advertencia, bloqueo, fondos_insuficientes;

    cajero_controlador dut (
        .clock                (clock),
        .reset                (reset),
        .tarjeta_recibida     (tarjeta_recibida),
        .tipo_trans           (tipo_trans),
        .digito_stb           (digito_stb),
        .digito               (digito),
        .pin                  (pin),
        .balance_inicial      (balance_inicial),
        .monto                (monto),
        .monto_stb            (monto_stb),
        .balance              (balance),
        .balance_actualizado  (balance_actualizado),
        .entregar_dinero      (entregar_dinero),
        .pin_incorrecto       (pin_incorrecto),
        .advertencia          (advertencia),
        .bloqueo              (bloqueo),
        .fondos_insuficientes (fondos_insuficientes)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Account model: balance, failed-attempt count, type of the open session.
    logic [63:0] m_bal;
    int          m_att;
    logic        s_tipo;

    typedef struct {
        logic        tipo;
        logic [63:0] bal_ini;
        logic [31:0] monto;
        logic [63:0] exp_bal;
        logic        e_act, e_ent, e_fi;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic e_act, input logic e_ent,
                              input logic e_inc, input logic e_fi);
        chk({tag, " balance"}, balance, m_bal);
        chk({tag, " actualizado"}, balance_actualizado, e_act);
        chk({tag, " entregar"}, entregar_dinero, e_ent);
        chk({tag, " pin_incorrecto"}, pin_incorrecto, e_inc);
        chk({tag, " fondos_insuf"}, fondos_insuficientes, e_fi);
        chk({tag, " advertencia"}, advertencia, m_att >= MAXI - 1);
        chk({tag, " bloqueo"}, bloqueo, m_att >= MAXI);
    endtask

    task automatic quiet(input string tag);
        check_outs(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_bal = '0;
        m_att = 0;
        quiet(tag);
    endtask

    task automatic insert_card(input logic tipo, input logic [63:0] bal);
        tarjeta_recibida = 1'b1;
        tipo_trans       = tipo;
        balance_inicial  = bal;
        step();
        tarjeta_recibida = 1'b0;
        tipo_trans       = 1'($urandom);
        balance_inicial  = {$urandom, $urandom};
        if (m_att < MAXI) begin
            m_bal  = bal;
            s_tipo = tipo;
        end
        quiet("card");
    endtask

    task automatic strobe_digit(input logic [3:0] d);
        digito     = d;
        digito_stb = 1'b1;
        step();
        digito_stb = 1'b0;
        digito     = 4'($urandom);
        quiet("digit");
    endtask

    task automatic enter_pin(input logic [15:0] entry, input logic noise, output logic got_inc);
        logic e_inc;
        e_inc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            strobe_digit(entry[15-4*i -: 4]);
            if (noise && i == 1) begin
                tarjeta_recibida = 1'b1;
                balance_inicial  = {$urandom, $urandom};
                monto_stb        = 1'b1;
                step();
                tarjeta_recibida = 1'b0;
                monto_stb        = 1'b0;
                quiet("pin noise");
            end
        end
        step();
        if (m_att < MAXI) begin
            if (entry == PIN_OK) m_att = 0;
            else begin
                m_att++;
                e_inc = 1'b1;
            end
        end
        got_inc = pin_incorrecto;
        check_outs("verify", 1'b0, 1'b0, e_inc, 1'b0);
    endtask

    task automatic send_amount(input logic [31:0] m, output logic got_act,
                               output logic got_ent, output logic got_fi);
        logic e_act, e_ent, e_fi;
        e_act = 1'b0; e_ent = 1'b0; e_fi = 1'b0;
        monto     = m;
        monto_stb = 1'b1;
        step();
        monto_stb = 1'b0;
        monto     = $urandom;
        quiet("monto");
        step();
        if (m_att < MAXI) begin
            if (s_tipo == 1'b0) begin
                m_bal = m_bal + 64'(m);
                e_act = 1'b1;
            end else if (64'(m) <= m_bal) begin
                m_bal = m_bal - 64'(m);
                e_act = 1'b1;
                e_ent = 1'b1;
            end else begin
                e_fi = 1'b1;
            end
        end
        got_act = balance_actualizado;
        got_ent = entregar_dinero;
        got_fi  = fondos_insuficientes;
        check_outs("proceso", e_act, e_ent, 1'b0, e_fi);
        step();
        quiet("post");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic gi, ga, ge, gf;
        int   inc_cnt;
        logic [63:0] rb;
        logic [31:0] rm;
        logic [15:0] wrong;

        reset = 1'b1; tarjeta_recibida = 1'b0; tipo_trans = 1'b0; digito_stb = 1'b0;
        digito = '0; pin = PIN_OK; balance_inicial = 64'd1000; monto = '0; monto_stb = 1'b0;
        m_bal = '0; m_att = 0; s_tipo = 1'b0;
        step();
        reset = 1'b0;
        quiet("reset");

        tbl[0] = '{1'b0, 64'd1000, 32'd250, 64'd1250, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 64'd1000, 32'd1000, 64'd0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 64'd1000, 32'd1001, 64'd1000, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 64'd1000, 32'd0, 64'd1000, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 64'd1000, 32'd0, 64'd1000, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 64'd1000, 32'd999, 64'd1, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 64'd1000, 32'hFFFF_FFFF, 64'h1_0000_03E7, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 64'hFFFF_FFFF_FFFF_FF00, 32'h200, 64'h100, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 64'h1_0000_0000, 32'hFFFF_FFFF, 64'd1, 1'b1, 1'b1, 1'b0};

        for (int v = 0; v < 9; v++) begin
            insert_card(tbl[v].tipo, tbl[v].bal_ini);
            enter_pin(PIN_OK, 1'b0, gi);
            send_amount(tbl[v].monto, ga, ge, gf);
            chk("tbl balance", balance, tbl[v].exp_bal);
            chk("tbl actualizado", ga, tbl[v].e_act);
            chk("tbl entregar", ge, tbl[v].e_ent);
            chk("tbl fondos", gf, tbl[v].e_fi);
        end

        // Lockout, then absorbing behaviour until reset.
        insert_card(1'b0, 64'd1000);
        inc_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            enter_pin(16'h1235, 1'b0, gi);
            inc_cnt += int'(gi);
            if (k == 1) chk("lock adv after 2nd", advertencia, 1'b1);
        end
        chk("lock pulse count", inc_cnt, 3);
        chk("lock bloqueo", bloqueo, 1'b1);
        enter_pin(PIN_OK, 1'b0, gi);
        send_amount(32'd100, ga, ge, gf);
        insert_card(1'b0, 64'd5);
        chk("lock balance held", balance, 64'd1000);
        do_reset("reset after lock");

        // Recovery: two misses, then the right PIN clears the warning.
        insert_card(1'b0, 64'd1000);
        enter_pin(16'h9999, 1'b0, gi);
        enter_pin(16'hABCD, 1'b0, gi);
        enter_pin(PIN_OK, 1'b0, gi);
        chk("recovery adv cleared", advertencia, 1'b0);
        send_amount(32'd250, ga, ge, gf);
        chk("recovery balance", balance, 64'd1250);

        // Reset after two digits; next session needs four fresh digits.
        insert_card(1'b0, 64'd1000);
        strobe_digit(4'h1);
        strobe_digit(4'h2);
        do_reset("reset mid-pin");
        insert_card(1'b1, 64'd1000);
        enter_pin(PIN_OK, 1'b0, gi);
        chk("fresh pin accepted", gi, 1'b0);
        send_amount(32'd400, ga, ge, gf);
        chk("fresh pin dispensed", ge, 1'b1);

        // Reset while the transaction result is pending cancels the pulse.
        insert_card(1'b0, 64'd1000);
        enter_pin(PIN_OK, 1'b0, gi);
        monto     = 32'd5;
        monto_stb = 1'b1;
        step();
        monto_stb = 1'b0;
        quiet("pending monto");
        do_reset("reset cancels pulse");

        for (int s = 0; s < 30; s++) begin
            digito_stb = 1'b1; monto_stb = 1'b1; digito = 4'($urandom);
            step();
            digito_stb = 1'b0; monto_stb = 1'b0;
            quiet("idle noise");
            case ($urandom_range(0, 3))
                0:       rb = 64'($urandom_range(0, 5000));
                1:       rb = {$urandom, $urandom};
                2:       rb = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 1000));
                default: rb = 64'($urandom);
            endcase
            insert_card(1'($urandom), rb);
            for (int w = $urandom_range(0, 2); w > 0 && m_att < MAXI; w--) begin
                wrong = 16'($urandom);
                if (wrong == PIN_OK) wrong = wrong ^ 16'h0001;
                enter_pin(wrong, 1'($urandom), gi);
            end
            if (m_att >= MAXI) begin
                enter_pin(PIN_OK, 1'b0, gi);
                send_amount($urandom, ga, ge, gf);
                do_reset("random reset");
            end else begin
                enter_pin(PIN_OK, 1'($urandom), gi);
                case ($urandom_range(0, 3))
                    0:       rm = $urandom;
                    1:       rm = m_bal[31:0];
                    2:       rm = m_bal[31:0] + 32'd1;
                    default: rm = 32'($urandom_range(0, 2000));
                endcase
                send_amount(rm, ga, ge, gf);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cajero_controlador.md
Name: cajero_controlador

Overview:
Main sequencing FSM of the automatic cashier. It accepts a card, collects a 4-digit PIN one nibble per strobe, and verifies it against the stored PIN, counting failed attempts up to lockout. It then executes one deposit or withdrawal against the account balance. It sits between the keypad/card front end (stimulus side) and the cash dispenser/status indicators.

Parameters:
PIN_DIGITOS, 4, number of BCD nibbles collected per PIN attempt (pin width = 4*PIN_DIGITOS)
MAX_INTENTOS, 3, failed attempts that cause lockout
ANCHO_BALANCE, 64, balance width
ANCHO_MONTO, 32, transaction amount width

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
tarjeta_recibida  in  1  card inserted; level sampled only in ESPERA_TARJETA
tipo_trans  in  1  0 = deposit, 1 = withdrawal; latched with card
digito_stb  in  1  one-cycle strobe: digito valid
digito  in  4  PIN digit, MSD first
pin  in  16  stored correct PIN, 4 nibbles, MSD in [15:12]
balance_inicial  in  64  account balance; latched with card
monto  in  32  transaction amount
monto_stb  in  1  one-cycle strobe: monto valid
balance  out  64  current working balance
balance_actualizado  out  1  one-cycle pulse: balance changed
entregar_dinero  out  1  one-cycle pulse: dispense cash
pin_incorrecto  out  1  one-cycle pulse: PIN attempt failed
advertencia  out  1  level: one attempt left before lockout
bloqueo  out  1  level: card locked, held until reset
fondos_insuficientes  out  1  one-cycle pulse: withdrawal rejected

Behaviour:
- Reset: state ESPERA_TARJETA, all outputs 0, balance 0, attempt counter 0, digit counter 0, PIN shift register 0.
- All outputs registered.
- ESPERA_TARJETA: tarjeta_recibida=1 -> latch balance_inicial into balance and latch tipo_trans; next RECIBIR_PIN. Strobes ignored here.
- RECIBIR_PIN: each digito_stb=1 cycle shifts {buf[11:0],digito} into the buffer and increments the digit counter. On the 4th strobe, next state VERIFICAR_PIN. No timeout. Nibbles >9 stored as-is.
- VERIFICAR_PIN (1 cycle), full 16-bit compare:
  - Match: clear attempts and advertencia; next ESPERA_MONTO.
  - Mismatch: attempts+1; pin_incorrecto pulses. If the new count = MAX_INTENTOS-1, set advertencia. If the new count = MAX_INTENTOS, set bloqueo and go to BLOQUEO. Otherwise return to RECIBIR_PIN with the digit counter cleared.
- Latency: 4th digito_stb at cycle N -> VERIFICAR_PIN at N+1 -> pin_incorrecto/advertencia/bloqueo visible at N+2.
- ESPERA_MONTO: monto_stb=1 -> latch monto; next PROCESAR.
- PROCESAR (1 cycle):
  - Deposit: balance += zero-extended monto, modulo 2^64 (wraps, no flag); balance_actualizado pulses.
  - Withdrawal with monto <= balance: balance -= monto; balance_actualizado and entregar_dinero pulse together.
  - Withdrawal with monto > balance: fondos_insuficientes pulses; balance unchanged.
  - Next state ESPERA_TARJETA in all cases.
  - Outputs visible the cycle after PROCESAR, i.e. 2 cycles after monto_stb.
- monto exactly equal to balance is accepted and leaves balance 0.
- BLOQUEO: absorbing. bloqueo=1 and advertencia=1 held, all inputs ignored; only reset exits.
- Attempt counter persists across cards. Cleared only by a correct PIN or by reset.
- tarjeta_recibida outside ESPERA_TARJETA is ignored. digito_stb outside RECIBIR_PIN is ignored. monto_stb outside ESPERA_MONTO is ignored.
- Reset asserted in any state, mid-PIN or mid-transaction, returns to reset values on the next edge. A pending pulse is cancelled.
- balance holds its value between sessions until the next card latches balance_inicial.

Decomposition:
- Shared package/header cajero_defs: state encodings (ESPERA_TARJETA, RECIBIR_PIN, VERIFICAR_PIN, ESPERA_MONTO, PROCESAR, BLOQUEO), TRANS_DEPOSITO=0, TRANS_RETIRO=1, width constants.
- One natural sub-module, cajero_pin_captura: digit shift register, digit counter and 16-bit compare. Outputs pin_completo and pin_coincide.
- Top-level FSM, attempt counter and balance arithmetic stay in cajero_controlador.

Test Plan:
- Setup for all scenarios: pin=16'h1234, balance_inicial=1000.
- Correct PIN, deposit: tipo_trans=0, digits 1,2,3,4, monto=250 -> balance=1250, balance_actualizado one pulse 2 cycles after monto_stb; no other flags.
- Correct PIN, withdrawal: tipo_trans=1, monto=1000 -> balance=0, balance_actualizado and entregar_dinero pulse in the same cycle.
- Insufficient funds: tipo_trans=1, monto=1001 -> fondos_insuficientes one pulse, balance stays 1000, entregar_dinero stays 0, FSM back in ESPERA_TARJETA.
- Lockout: enter 1,2,3,5 three times -> pin_incorrecto pulses 3 times; advertencia=1 after the 2nd; bloqueo=1 after the 3rd; a subsequent correct PIN, monto_stb and tarjeta_recibida produce no response until reset.
- Recovery and reset: two wrong PINs then 1,2,3,4 -> advertencia clears and transaction proceeds. Separately, reset after 2 digits -> all outputs 0, and the next card session requires 4 fresh digits.
